bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-requester arbiter sharing one single-port, synchronous-read BRAM in the GBC memory subsystem. Requester A (CPU memory-router side) and requester B (DMA / PPU fetch side) issue one-byte read or write commands. The block selects at most one command per cycle, drives registered BRAM controls, and routes the read byte back to the requester that issued it with a valid pulse. The address is masked so every BRAM instance starts at 0x0000.

## Interface
- P_OFFSET_MASK, 16'h00FF: AND-mask applied to the winning address before it reaches the BRAM.
- I_CLK  in  1  clock; every register updates on the rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_A_REQ, I_B_REQ  in  1  command request; held high until the matching GNT is seen.
- I_A_WE, I_B_WE  in  1  1 = write, 0 = read; qualified by REQ.
- I_A_ADDR, I_B_ADDR  in  16  byte address.
- I_A_WDATA, I_B_WDATA  in  8  write data.
- O_A_GNT, O_B_GNT  out  1  one-cycle pulse: command accepted.
- O_A_RVALID, O_B_RVALID  out  1  one-cycle pulse: read data valid.
- O_A_RDATA, O_B_RDATA  out  8  read data; holds its value between pulses.
- O_BRAM_EN, O_BRAM_WE  out  1  BRAM enable and write enable, registered.
- O_BRAM_ADDR  out  16  equals winning address & P_OFFSET_MASK, registered.
- O_BRAM_DIN  out  8  write data, registered.
- I_BRAM_DOUT  in  8  BRAM read data, valid on the cycle after EN with WE=0.

## Operation
- Effective request: REQ_x & ~O_x_GNT. A requester whose GNT is high this cycle cannot win this cycle, so each requester is granted at most once every 2 cycles.
- Arbitration (cycle N): the winner is chosen among effective requests by the policy in Configuration. At the edge ending cycle N the block registers:
  - winner's GNT = 1;
  - O_BRAM_EN = 1;
  - O_BRAM_WE = winner WE;
  - O_BRAM_ADDR = winner ADDR & P_OFFSET_MASK;
  - O_BRAM_DIN = winner WDATA.
- No effective request: EN, WE and both GNT register to 0. ADDR and DIN hold their previous values.
- Return pipeline: a 2-stage tag records {read_valid, requester_id} for each issued command.
  - Stage 1 is aligned with the BRAM command cycle.
  - Stage 2 is aligned with I_BRAM_DOUT.
  - At the edge ending stage 2, I_BRAM_DOUT is captured into the tagged requester's RDATA, and that requester's RVALID is set for one cycle.
  - Writes produce no RVALID.
- The pipeline is fully overlapped: a new grant may issue every cycle, alternating requesters. Returns are in issue order.
- Back-to-back accesses to the same address, write then read: the read observes the written value. This follows from BRAM order; the block does no forwarding.
- The other requester's RDATA is never modified by a return.

## Timing
- Reset values:
  - all GNT, RVALID, O_BRAM_EN and O_BRAM_WE = 0;
  - O_BRAM_ADDR = 0, O_BRAM_DIN = 0, both RDATA = 0;
  - tag pipeline cleared;
  - round-robin pointer set to prefer A.
- Reset mid-operation: in-flight reads are discarded. No RVALID is asserted for them after reset.
- REQ sampled high in cycle N:
  - GNT and BRAM command in N+1;
  - I_BRAM_DOUT in N+2;
  - RVALID and RDATA in N+3.
- Read latency is 3 cycles REQ-to-RVALID when uncontended.
- A requester must hold REQ, WE, ADDR and WDATA stable until it sees GNT. It may deassert REQ or present a new command in the GNT cycle; the new command is not eligible until the following cycle.
- Peak throughput: 1 command per cycle with both requesters active; 1 per 2 cycles for a single requester.

## Configuration
- BRAM_ARB_RR_EN defined: round-robin.
  - A 1-bit pointer selects the preferred requester.
  - On a grant, the pointer flips to favour the requester that was not granted.
  - Contended grants alternate A, B, A, B.
- BRAM_ARB_RR_EN undefined: fixed priority, A always wins when both effective requests are high. B is served only in cycles where A is ineligible (A idle or A's GNT high).

## Test plan
- Reset while a read is in flight: A read of 0x0010 issued; I_RESET high in the cycle the BRAM command is active -> all outputs 0, no O_A_RVALID ever pulses for that read.
- Single read: BRAM preloaded 0x1234 -> 0x5A; A reads 0x1234 with P_OFFSET_MASK = 16'h0FFF -> O_BRAM_ADDR = 0x0234 in N+1, O_A_RVALID = 1 with O_A_RDATA = 0x5A in N+3, O_B_RVALID stays 0.
- Write then read: A writes 0x0005 <= 0xC3, then reads 0x0005 as soon as GNT allows -> O_BRAM_WE = 1 exactly once, O_A_RDATA = 0xC3, no RVALID for the write.
- Contention: A and B both request reads continuously from cycle N, with different addresses:
  - RR build -> grants A, B, A, B in N+1..N+4, and each RDATA matches its own address;
  - fixed build -> A granted in N+1 and N+3, B in N+2 and N+4.
- Interleaved return routing: A reads 0x0001 (0x11) while B reads 0x0002 (0x22), granted on consecutive cycles -> O_A_RDATA = 0x11 with O_A_RVALID one cycle before O_B_RDATA = 0x22 with O_B_RVALID.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of one single-port, synchronous-read BRAM.
// Fixed priority (A first) by default; define BRAM_ARB_RR_EN for round-robin arbitration.
`timescale 1ns/1ps
module bram_port_arbiter #(
   parameter logic [15:0] P_OFFSET_MASK = 16'h00FF
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_A_REQ,
   input  logic        I_A_WE,
   input  logic [15:0] I_A_ADDR,
   input  logic [7:0]  I_A_WDATA,
   input  logic        I_B_REQ,
   input  logic        I_B_WE,
   input  logic [15:0] I_B_ADDR,
   input  logic [7:0]  I_B_WDATA,
   output logic        O_A_GNT,
   output logic        O_B_GNT,
   output logic        O_A_RVALID,
   output logic        O_B_RVALID,
   output logic [7:0]  O_A_RDATA,
   output logic [7:0]  O_B_RDATA,
   output logic        O_BRAM_EN,
   output logic        O_BRAM_WE,
   output logic [15:0] O_BRAM_ADDR,
   output logic [7:0]  O_BRAM_DIN,
   input  logic [7:0]  I_BRAM_DOUT
);

   localparam int N_REQ = 2;

   // Index 0 is requester A, index 1 is requester B.
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] req_we;
   logic [15:0]      req_addr  [N_REQ];
   logic [7:0]       req_wdata [N_REQ];

   logic [N_REQ-1:0] gnt_reg;
   logic [N_REQ-1:0] gnt_next;
   logic [N_REQ-1:0] eff_req;
   logic             win_any;
   logic             win_id;

   logic             en_reg;
   logic             we_reg;
   logic [15:0]      addr_reg;
   logic [7:0]       din_reg;

   logic             tag1_valid_reg;
   logic             tag1_id_reg;
   logic             tag2_valid_reg;
   logic             tag2_id_reg;

   assign req          = {I_B_REQ, I_A_REQ};
   assign req_we       = {I_B_WE, I_A_WE};
   assign req_addr[0]  = I_A_ADDR;
   assign req_addr[1]  = I_B_ADDR;
   assign req_wdata[0] = I_A_WDATA;
   assign req_wdata[1] = I_B_WDATA;

   // A requester being granted this cycle is still presenting the old command.
   assign eff_req = req & ~gnt_reg;
   assign win_any = |eff_req;

`ifdef BRAM_ARB_RR_EN
   logic rr_ptr_reg;
   logic rr_ptr_next;

   always_comb begin
      win_id      = ~eff_req[0];
      rr_ptr_next = rr_ptr_reg;
      if (eff_req[0] && eff_req[1]) begin
         win_id = rr_ptr_reg;
      end
      if (win_any) begin
         rr_ptr_next = ~win_id;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         rr_ptr_reg <= 1'b0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end
`else
   always_comb begin
      win_id = ~eff_req[0];
   end
`endif

   always_comb begin
      gnt_next = '0;
      if (win_any) begin
         gnt_next[win_id] = 1'b1;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         gnt_reg        <= '0;
         en_reg         <= 1'b0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         din_reg        <= '0;
         tag1_valid_reg <= 1'b0;
         tag1_id_reg    <= 1'b0;
         tag2_valid_reg <= 1'b0;
         tag2_id_reg    <= 1'b0;
      end else begin
         gnt_reg        <= gnt_next;
         en_reg         <= win_any;
         we_reg         <= win_any & req_we[win_id];
         if (win_any) begin
            addr_reg <= req_addr[win_id] & P_OFFSET_MASK;
            din_reg  <= req_wdata[win_id];
         end
         tag1_valid_reg <= win_any & ~req_we[win_id];
         tag1_id_reg    <= win_id;
         tag2_valid_reg <= tag1_valid_reg;
         tag2_id_reg    <= tag1_id_reg;
      end
   end

   // Per-requester return registers; only the tagged owner captures BRAM data.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ret
         logic       rvalid_reg;
         logic [7:0] rdata_reg;
         logic       hit;

         assign hit = tag2_valid_reg && (tag2_id_reg == 1'(gi));

         always_ff @(posedge I_CLK) begin
            if (I_RESET) begin
               rvalid_reg <= 1'b0;
               rdata_reg  <= '0;
            end else begin
               rvalid_reg <= hit;
               if (hit) begin
                  rdata_reg <= I_BRAM_DOUT;
               end
            end
         end
      end
   endgenerate

   assign O_A_GNT     = gnt_reg[0];
   assign O_B_GNT     = gnt_reg[1];
   assign O_A_RVALID  = g_ret[0].rvalid_reg;
   assign O_B_RVALID  = g_ret[1].rvalid_reg;
   assign O_A_RDATA   = g_ret[0].rdata_reg;
   assign O_B_RDATA   = g_ret[1].rdata_reg;
   assign O_BRAM_EN   = en_reg;
   assign O_BRAM_WE   = we_reg;
   assign O_BRAM_ADDR = addr_reg;
   assign O_BRAM_DIN  = din_reg;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed vector table, reset-in-flight sequence,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

   localparam logic [15:0] MASK   = 16'h0FFF;
   localparam int          N_ROWS = 23;
   localparam int          N_RND  = 2000;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, b_addr;
   logic [7:0]  a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [7:0]  a_rdata, b_rdata;
   logic        bram_en, bram_we;
   logic [15:0] bram_addr;
   logic [7:0]  bram_din, bram_dout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(.P_OFFSET_MASK(MASK)) dut (
      .I_CLK(clk), .I_RESET(reset),
      .I_A_REQ(a_req), .I_A_WE(a_we), .I_A_ADDR(a_addr), .I_A_WDATA(a_wdata),
      .I_B_REQ(b_req), .I_B_WE(b_we), .I_B_ADDR(b_addr), .I_B_WDATA(b_wdata),
      .O_A_GNT(a_gnt), .O_B_GNT(b_gnt),
      .O_A_RVALID(a_rvalid), .O_B_RVALID(b_rvalid),
      .O_A_RDATA(a_rdata), .O_B_RDATA(b_rdata),
      .O_BRAM_EN(bram_en), .O_BRAM_WE(bram_we),
      .O_BRAM_ADDR(bram_addr), .O_BRAM_DIN(bram_din),
      .I_BRAM_DOUT(bram_dout)
   );

   function automatic logic [7:0] pattern(input int i);
      case (i)
         'h234:   return 8'h5A;
         'h001:   return 8'h11;
         'h002:   return 8'h22;
         'h100:   return 8'h5C;
         'h200:   return 8'hE7;
         'h010:   return 8'h3D;
         default: return 8'(i * 13 + 7);
      endcase
   endfunction

   // Behavioural synchronous-read BRAM; mem_init reloads the preset contents.
   logic [7:0] bram [4096];
   logic       mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) bram[i] <= pattern(i);
      end else if (bram_en) begin
         if (bram_we) bram[bram_addr[11:0]] <= bram_din;
         else         bram_dout <= bram[bram_addr[11:0]];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic a_req, a_we; logic [15:0] a_addr; logic [7:0] a_wdata;
      logic b_req, b_we; logic [15:0] b_addr; logic [7:0] b_wdata;
      logic x_a_gnt, x_b_gnt, x_en, x_we; logic [15:0] x_addr; logic [7:0] x_din;
      logic x_a_rv, x_b_rv; logic [7:0] x_a_rd, x_b_rd;
   } vec_t;
   vec_t tbl [N_ROWS];

   task automatic in_a(input int k, input logic r, input logic w, input logic [15:0] ad, input logic [7:0] wd);
      tbl[k].a_req = r; tbl[k].a_we = w; tbl[k].a_addr = ad; tbl[k].a_wdata = wd;
   endtask
   task automatic in_b(input int k, input logic r, input logic w, input logic [15:0] ad, input logic [7:0] wd);
      tbl[k].b_req = r; tbl[k].b_we = w; tbl[k].b_addr = ad; tbl[k].b_wdata = wd;
   endtask
   task automatic ex(input int k, input logic ag, input logic bg, input logic en, input logic we,
                     input logic [15:0] ad, input logic [7:0] din, input logic arv, input logic [7:0] ard,
                     input logic brv, input logic [7:0] brd);
      tbl[k].x_a_gnt = ag; tbl[k].x_b_gnt = bg; tbl[k].x_en = en; tbl[k].x_we = we;
      tbl[k].x_addr = ad; tbl[k].x_din = din; tbl[k].x_a_rv = arv; tbl[k].x_a_rd = ard;
      tbl[k].x_b_rv = brv; tbl[k].x_b_rd = brd;
   endtask

   task automatic do_reset();
      reset = 1'b1; mem_init = 1'b1;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      repeat (3) step();
      reset = 1'b0; mem_init = 1'b0;
   endtask

   function automatic logic [15:0] rand_addr();
      logic [15:0] a;
      a = 16'($urandom);
      a[11:3] = '0;
      return a;
   endfunction

   // Reference model state
   typedef struct { int due; logic id; logic [7:0] data; } ret_t;
   ret_t        retq [$];
   logic [7:0]  ref_mem [4096];
   logic        m_gnt_a, m_gnt_b, m_en, m_we, m_ptr, m_rv_a, m_rv_b;
   logic [15:0] m_addr;
   logic [7:0]  m_din, m_rd_a, m_rd_b;

   initial begin
      ret_t        r;
      logic        elig_a, elig_b, pick_b, w_we;
      logic [15:0] w_addr;
      logic [7:0]  w_data;
      int          n_reads;

      for (int k = 0; k < N_ROWS; k++) begin
         in_a(k, 0, 0, 16'h0000, 8'h00);
         in_b(k, 0, 0, 16'h0000, 8'h00);
      end
      // Single read with masking, then write/read-back of 0x0005
      ex(0,  0,0,0,0,16'h0000,8'h00, 0,8'h00, 0,8'h00); in_a(0, 1,0,16'h1234,8'h00);
      ex(1,  1,0,1,0,16'h0234,8'h00, 0,8'h00, 0,8'h00);
      ex(2,  0,0,0,0,16'h0234,8'h00, 0,8'h00, 0,8'h00);
      ex(3,  0,0,0,0,16'h0234,8'h00, 1,8'h5A, 0,8'h00);
      ex(4,  0,0,0,0,16'h0234,8'h00, 0,8'h5A, 0,8'h00); in_a(4, 1,1,16'h0005,8'hC3);
      ex(5,  1,0,1,1,16'h0005,8'hC3, 0,8'h5A, 0,8'h00); in_a(5, 1,0,16'h0005,8'h00);
      ex(6,  0,0,0,0,16'h0005,8'hC3, 0,8'h5A, 0,8'h00); in_a(6, 1,0,16'h0005,8'h00);
      ex(7,  1,0,1,0,16'h0005,8'h00, 0,8'h5A, 0,8'h00);
      ex(8,  0,0,0,0,16'h0005,8'h00, 0,8'h5A, 0,8'h00);
      ex(9,  0,0,0,0,16'h0005,8'h00, 1,8'hC3, 0,8'h00);
      // Interleaved A/B returns
      ex(10, 0,0,0,0,16'h0005,8'h00, 0,8'hC3, 0,8'h00); in_a(10, 1,0,16'h0001,8'h00);
      ex(11, 1,0,1,0,16'h0001,8'h00, 0,8'hC3, 0,8'h00); in_b(11, 1,0,16'h0002,8'h00);
      ex(12, 0,1,1,0,16'h0002,8'h00, 0,8'hC3, 0,8'h00);
      ex(13, 0,0,0,0,16'h0002,8'h00, 1,8'h11, 0,8'h00);
      ex(14, 0,0,0,0,16'h0002,8'h00, 0,8'h11, 1,8'h22);
      // Continuous contention: alternation A,B,A,B
      ex(15, 0,0,0,0,16'h0002,8'h00, 0,8'h11, 0,8'h22);
      ex(16, 1,0,1,0,16'h0100,8'h00, 0,8'h11, 0,8'h22);
      ex(17, 0,1,1,0,16'h0200,8'h00, 0,8'h11, 0,8'h22);
      ex(18, 1,0,1,0,16'h0100,8'h00, 1,8'h5C, 0,8'h22);
      ex(19, 0,1,1,0,16'h0200,8'h00, 0,8'h5C, 1,8'hE7);
      ex(20, 0,0,0,0,16'h0200,8'h00, 1,8'h5C, 0,8'hE7);
      ex(21, 0,0,0,0,16'h0200,8'h00, 0,8'h5C, 1,8'hE7);
      ex(22, 0,0,0,0,16'h0200,8'h00, 0,8'h5C, 0,8'hE7);
      for (int k = 15; k <= 18; k++) in_b(k, 1,0,16'h8200,8'h00);
      for (int k = 15; k <= 17; k++) in_a(k, 1,0,16'hF100,8'h00);

      do_reset();
      for (int k = 0; k < N_ROWS; k++) begin
         check($sformatf("row%0d_a_gnt", k),  a_gnt,     tbl[k].x_a_gnt);
         check($sformatf("row%0d_b_gnt", k),  b_gnt,     tbl[k].x_b_gnt);
         check($sformatf("row%0d_en", k),     bram_en,   tbl[k].x_en);
         check($sformatf("row%0d_we", k),     bram_we,   tbl[k].x_we);
         check($sformatf("row%0d_addr", k),   bram_addr, tbl[k].x_addr);
         check($sformatf("row%0d_din", k),    bram_din,  tbl[k].x_din);
         check($sformatf("row%0d_a_rv", k),   a_rvalid,  tbl[k].x_a_rv);
         check($sformatf("row%0d_b_rv", k),   b_rvalid,  tbl[k].x_b_rv);
         check($sformatf("row%0d_a_rd", k),   a_rdata,   tbl[k].x_a_rd);
         check($sformatf("row%0d_b_rd", k),   b_rdata,   tbl[k].x_b_rd);
         $display("row %0d: a_req=%0b b_req=%0b gnt=%0b%0b en=%0b addr=%h rv=%0b%0b",
                  k, tbl[k].a_req, tbl[k].b_req, a_gnt, b_gnt, bram_en, bram_addr, a_rvalid, b_rvalid);
         a_req = tbl[k].a_req; a_we = tbl[k].a_we; a_addr = tbl[k].a_addr; a_wdata = tbl[k].a_wdata;
         b_req = tbl[k].b_req; b_we = tbl[k].b_we; b_addr = tbl[k].b_addr; b_wdata = tbl[k].b_wdata;
         step();
      end

      // Reset while a read of 0x0010 is in its BRAM command cycle
      a_req = 1; a_we = 0; a_addr = 16'h0010; a_wdata = 8'h00;
      step();
      check("rst_cmd_gnt", a_gnt, 1'b1);
      check("rst_cmd_en", bram_en, 1'b1);
      reset = 1'b1; a_req = 0;
      step();
      reset = 1'b0;
      check("rst_gnt", {a_gnt, b_gnt}, 2'b00);
      check("rst_en_we", {bram_en, bram_we}, 2'b00);
      check("rst_addr", bram_addr, 16'h0000);
      check("rst_din", bram_din, 8'h00);
      check("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_no_rvalid%0d", i), {a_rvalid, b_rvalid}, 2'b00);
         check($sformatf("rst_a_rdata%0d", i), a_rdata, 8'h00);
         step();
      end
      $display("reset-in-flight sequence done");

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 4096; i++) ref_mem[i] = pattern(i);
      m_gnt_a = 0; m_gnt_b = 0; m_en = 0; m_we = 0; m_ptr = 0;
      m_addr = 0; m_din = 0; m_rd_a = 0; m_rd_b = 0;
      n_reads = 0;
      for (int cyc = 0; cyc < N_RND; cyc++) begin
         m_rv_a = 0; m_rv_b = 0;
         while (retq.size() > 0 && retq[0].due == cyc) begin
            r = retq.pop_front();
            if (r.id) begin m_rv_b = 1; m_rd_b = r.data; end
            else      begin m_rv_a = 1; m_rd_a = r.data; end
         end
         check("rnd_a_gnt", a_gnt, m_gnt_a);
         check("rnd_b_gnt", b_gnt, m_gnt_b);
         check("rnd_en", bram_en, m_en);
         check("rnd_we", bram_we, m_we);
         check("rnd_addr", bram_addr, m_addr);
         check("rnd_din", bram_din, m_din);
         check("rnd_a_rv", a_rvalid, m_rv_a);
         check("rnd_b_rv", b_rvalid, m_rv_b);
         check("rnd_a_rd", a_rdata, m_rd_a);
         check("rnd_b_rd", b_rdata, m_rd_b);

         // Requesters hold a command until granted, then may issue a new one
         if (!a_req || m_gnt_a) begin
            a_req = (cyc < N_RND - 10) && ($urandom_range(0, 3) != 0);
            a_we = ($urandom_range(0, 2) == 0); a_addr = rand_addr(); a_wdata = 8'($urandom);
         end
         if (!b_req || m_gnt_b) begin
            b_req = (cyc < N_RND - 10) && ($urandom_range(0, 3) != 0);
            b_we = ($urandom_range(0, 2) == 0); b_addr = rand_addr(); b_wdata = 8'($urandom);
         end

         elig_a = a_req && !m_gnt_a;
         elig_b = b_req && !m_gnt_b;
`ifdef BRAM_ARB_RR_EN
         pick_b = elig_b && (!elig_a || m_ptr);
`else
         pick_b = elig_b && !elig_a;
`endif
         m_gnt_a = elig_a && !pick_b;
         m_gnt_b = pick_b;
         if (elig_a || elig_b) begin
            w_we   = pick_b ? b_we : a_we;
            w_addr = (pick_b ? b_addr : a_addr) & MASK;
            w_data = pick_b ? b_wdata : a_wdata;
            m_en = 1; m_we = w_we; m_addr = w_addr; m_din = w_data;
            if (w_we) ref_mem[w_addr[11:0]] = w_data;
            else begin
               retq.push_back('{cyc + 3, pick_b, ref_mem[w_addr[11:0]]});
               n_reads++;
            end
            m_ptr = !pick_b;
         end else begin
            m_en = 0; m_we = 0;
         end
         step();
      end
      check("rnd_queue_drained", retq.size(), 0);
      $display("random phase: %0d cycles, %0d reads issued", N_RND, n_reads);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
